alu_status_unit: RTL and testbench

ALU_STATUS_UNIT -- requirements
Module: alu_status_unit

---
 rtl/alu_status_pkg.sv | 23 ++
 rtl/alu_flag_calc.sv | 39 +++
 rtl/alu_status_unit.sv | 76 +++++++
 tb/tb_alu_status_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_status_pkg.sv
// Shared flag layout for the ALU status unit: bit positions of N/Z/C/V and the
// packed flag vector type used between the flag calculator and the registers.
package alu_status_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] alu_flags_t;

  function automatic alu_flags_t pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    alu_flags_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational N/Z/C/V derivation from an ALU result and operand sign bits.
// Logic operations report only Z; N, C and V are forced low for them.
module alu_flag_calc
  import alu_status_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry_out,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             is_arithmetic,
  input  logic             is_subtract,
  output alu_flags_t       flags
);

  logic res_msb;
  logic sign_flip;
  logic ops_compatible;

  assign res_msb   = result[WIDTH-1];
  assign sign_flip = (res_msb != a_msb);

  // NOTE: every signal driven from always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ops_compatible = 1'b0;
    flags          = '0;
    // Add overflows on like-signed operands, subtract on unlike-signed ones.
    if (is_subtract) ops_compatible = (a_msb != b_msb);
    else             ops_compatible = (a_msb == b_msb);

    flags = pack_flags(res_msb & is_arithmetic,
                       (result == '0),
                       carry_out & is_arithmetic,
                       ops_compatible & sign_flip & is_arithmetic);
  end

endmodule

// File: rtl/alu_status_unit.sv
// Registered ALU status flags with a saturating overflow-event counter.
// Define ALU_STATUS_STICKY_EN to add the sticky_q accumulated-flags output.
module alu_status_unit
  import alu_status_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     result,
  input  logic                 carry_out,
  input  logic                 a_msb,
  input  logic                 b_msb,
  input  logic                 is_arithmetic,
  input  logic                 is_subtract,
  input  logic                 flags_clear,
  output alu_flags_t           flags_q,
  output logic                 out_valid,
`ifdef ALU_STATUS_STICKY_EN
  output alu_flags_t           sticky_q,
`endif
  output logic [CNT_WIDTH-1:0] ovf_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  alu_flags_t flags_d;

  alu_flag_calc #(.WIDTH(WIDTH)) u_calc (
    .result        (result),
    .carry_out     (carry_out),
    .a_msb         (a_msb),
    .b_msb         (b_msb),
    .is_arithmetic (is_arithmetic),
    .is_subtract   (is_subtract),
    .flags         (flags_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) flags_q <= flags_d;
    end
  end

  // Clear outranks a same-cycle overflow event; the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (flags_clear) begin
      ovf_count <= '0;
    end else if (in_valid && flags_d[FLAG_V] && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

`ifdef ALU_STATUS_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else if (flags_clear) begin
      sticky_q <= '0;
    end else if (in_valid) begin
      sticky_q <= sticky_q | flags_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_status_unit.sv
// Self-checking bench for alu_status_unit (WIDTH=4, CNT_WIDTH=2): vector table
// plus hand sequences for hold, saturation, clear priority and async reset.
module tb_alu_status_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] result;
  logic       carry_out;
  logic       a_msb;
  logic       b_msb;
  logic       is_arithmetic;
  logic       is_subtract;
  logic       flags_clear;
  logic [3:0] flags_q;
  logic       out_valid;
  logic [1:0] ovf_count;
`ifdef ALU_STATUS_STICKY_EN
  logic [3:0] sticky_q;
`endif

  alu_status_unit #(.WIDTH(4), .CNT_WIDTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .result        (result),
    .carry_out     (carry_out),
    .a_msb         (a_msb),
    .b_msb         (b_msb),
    .is_arithmetic (is_arithmetic),
    .is_subtract   (is_subtract),
    .flags_clear   (flags_clear),
    .flags_q       (flags_q),
    .out_valid     (out_valid),
`ifdef ALU_STATUS_STICKY_EN
    .sticky_q      (sticky_q),
`endif
    .ovf_count     (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       vld;
    logic [3:0] res;
    logic       co;
    logic       am;
    logic       bm;
    logic       ar;
    logic       sb;
    logic [3:0] exp_flags;
  } vec_t;

  typedef struct packed {
    logic [3:0] flags;
    logic       ov;
    logic [1:0] cnt;
    logic [3:0] sticky;
  } exp_t;

  exp_t       sb_q[$];
  vec_t       vecs[9];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_flags  = '0;
  logic [1:0] m_cnt    = '0;
  logic [3:0] m_sticky = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic vld, input logic [3:0] res,
                              input logic co, input logic am, input logic bm,
                              input logic ar, input logic sb, input logic [3:0] ef);
    vec_t v;
    v.name = name; v.vld = vld; v.res = res; v.co = co; v.am = am; v.bm = bm;
    v.ar = ar; v.sb = sb; v.exp_flags = ef;
    return v;
  endfunction

  // Drive one cycle at the falling edge, predict, then compare after the rising edge.
  task automatic drive(input vec_t v, input logic clr);
    exp_t e;
    @(negedge clk);
    in_valid = v.vld; result = v.res; carry_out = v.co; a_msb = v.am; b_msb = v.bm;
    is_arithmetic = v.ar; is_subtract = v.sb; flags_clear = clr;
    if (v.vld) m_flags = v.exp_flags;
    if (clr) m_cnt = '0;
    else if (v.vld && v.exp_flags[0] && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    if (clr) m_sticky = '0;
    else if (v.vld) m_sticky = m_sticky | v.exp_flags;
    e.flags = m_flags; e.ov = v.vld; e.cnt = m_cnt; e.sticky = m_sticky;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({v.name, ".flags"}, 32'(flags_q), 32'(e.flags));
    check({v.name, ".out_valid"}, 32'(out_valid), 32'(e.ov));
    check({v.name, ".ovf_count"}, 32'(ovf_count), 32'(e.cnt));
`ifdef ALU_STATUS_STICKY_EN
    check({v.name, ".sticky"}, 32'(sticky_q), 32'(e.sticky));
`endif
  endtask

  initial begin
    vec_t idle;
    vec_t ovf_sub;
    vec_t ovf_add;

    vecs[0] = mk("add_plain",   1, 4'b0101, 0, 0, 0, 1, 0, 4'b0000);
    vecs[1] = mk("add_ovf_neg", 1, 4'b1000, 0, 0, 0, 1, 0, 4'b1001);
    vecs[2] = mk("logic_msb",   1, 4'b1011, 0, 0, 0, 0, 0, 4'b0000);
    vecs[3] = mk("logic_zero",  1, 4'b0000, 0, 0, 0, 0, 0, 4'b0100);
    vecs[4] = mk("add_zc_ovf",  1, 4'b0000, 1, 1, 1, 1, 0, 4'b0111);
    vecs[5] = mk("sub_ovf",     1, 4'b1001, 0, 0, 1, 1, 1, 4'b1001);
    vecs[6] = mk("sub_nc",      1, 4'b1111, 1, 1, 1, 1, 1, 4'b1010);
    vecs[7] = mk("add_zc",      1, 4'b0000, 1, 0, 1, 1, 0, 4'b0110);
    vecs[8] = mk("logic_subig", 1, 4'b1111, 1, 0, 1, 0, 1, 4'b0000);
    idle    = mk("idle",        0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    ovf_sub = mk("sat_sub",     1, 4'b0111, 0, 1, 0, 1, 1, 4'b0001);
    ovf_add = mk("clr_add",     1, 4'b1000, 0, 0, 0, 1, 0, 4'b1001);

    rst_n = 1'b0; in_valid = 0; result = '0; carry_out = 0; a_msb = 0; b_msb = 0;
    is_arithmetic = 0; is_subtract = 0; flags_clear = 0;
    #3;
    check("reset.flags", 32'(flags_q), 32'h0);
    check("reset.out_valid", 32'(out_valid), 32'h0);
    check("reset.ovf_count", 32'(ovf_count), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) drive(vecs[i], 1'b0);

    drive(idle, 1'b1);
    check("clear.ovf_count", 32'(ovf_count), 32'h0);

    // Logic zero, then three idle cycles must hold flags with out_valid low.
    drive(vecs[3], 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(idle, 1'b0);
      check("hold.flags", 32'(flags_q), 32'h4);
    end

    // Saturating count with CNT_WIDTH=2: 1,2,3,3,3.
    for (int i = 0; i < 5; i++) begin
      logic [1:0] want;
      want = (i < 3) ? 2'(i + 1) : 2'd3;
      drive(ovf_sub, 1'b0);
      check("sat.count", 32'(ovf_count), 32'(want));
    end

    drive(ovf_add, 1'b1);
    check("clr_prio.count", 32'(ovf_count), 32'h0);
    check("clr_prio.v", 32'(flags_q[0]), 32'h1);
`ifdef ALU_STATUS_STICKY_EN
    check("clr_prio.sticky", 32'(sticky_q), 32'h0);
`endif

    // Mid-stream reset with a valid update pending; outputs clear before any edge.
    drive(vecs[4], 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst.flags", 32'(flags_q), 32'h0);
    check("async_rst.out_valid", 32'(out_valid), 32'h0);
    check("async_rst.ovf_count", 32'(ovf_count), 32'h0);
`ifdef ALU_STATUS_STICKY_EN
    check("async_rst.sticky", 32'(sticky_q), 32'h0);
`endif
    m_flags = '0; m_cnt = '0; m_sticky = '0;
    #1 rst_n = 1'b1;
    drive(vecs[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
